// File: rtl/seq_restoring_divider.sv
// ---------------------------------------------------------------------------
// seq_restoring_divider
//
// Multi-cycle unsigned restoring divider. It produces one quotient bit per
// clock, MSB first. Paired with the 4x4 array multiplier: dividing m*q by m
// returns q with a zero remainder.
//
// Handshake: start is only looked at while busy=0. An accepted start with a
// non-zero divisor runs DIVIDEND_W iterations and then raises done. A zero
// divisor skips the iteration and flags div_by_zero on the same edge. done is
// a level and stays high until the next accepted start.
//
// Ports
//   clk          in   1           rising-edge clock
//   rst_n        in   1           asynchronous active-low reset
//   start        in   1           request a divide (ignored while busy)
//   dividend     in   DIVIDEND_W  unsigned dividend, sampled on accepted start
//   divisor      in   DIVISOR_W   unsigned divisor, sampled on accepted start
//   busy         out  1           high while iterating
//   done         out  1           results valid, held until next accepted start
//   div_by_zero  out  1           last accepted divisor was zero
//   quotient     out  DIVIDEND_W  unsigned quotient
//   remainder    out  DIVISOR_W   unsigned remainder (< divisor when divisor != 0)
// ---------------------------------------------------------------------------
module seq_restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic                  div_by_zero,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder
);

  // Iteration counter only has to reach DIVIDEND_W-1.
  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [DIVISOR_W-1:0]    divisor_reg;
  // Partial remainder carries one spare bit so the trial value never wraps.
  logic [DIVISOR_W:0]      r_reg;
  logic [DIVIDEND_W-1:0]   q_reg;
  logic                    busy_reg;
  logic                    done_reg;
  logic                    dbz_reg;
  logic [DIVIDEND_W-1:0]   quotient_reg;
  logic [DIVISOR_W-1:0]    remainder_reg;

  // One restoring step, computed from the current registers.
  logic [DIVISOR_W:0]      trial;
  logic [DIVISOR_W:0]      divisor_ext;
  logic                    fits;
  logic [DIVISOR_W:0]      r_next;
  logic [DIVIDEND_W-1:0]   q_next;
  logic                    accept;

  always_comb begin
    trial       = {r_reg[DIVISOR_W-1:0], q_reg[DIVIDEND_W-1]};
    divisor_ext = {1'b0, divisor_reg};
    fits        = (trial >= divisor_ext);
    r_next      = fits ? (trial - divisor_ext) : trial;
    q_next      = {q_reg[DIVIDEND_W-2:0], fits};
  end

  // A start is honoured whenever we are not iterating.
  assign accept = start && (state_reg != RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      divisor_reg   <= '0;
      r_reg         <= '0;
      q_reg         <= '0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
      dbz_reg       <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if (accept) begin
            if (divisor == '0) begin
              // No iteration needed: publish the saturated result at once.
              state_reg     <= DONE;
              busy_reg      <= 1'b0;
              done_reg      <= 1'b1;
              dbz_reg       <= 1'b1;
              quotient_reg  <= '1;
              remainder_reg <= '0;
              divisor_reg   <= divisor;
              cnt_reg       <= '0;
            end else begin
              state_reg   <= RUN;
              busy_reg    <= 1'b1;
              done_reg    <= 1'b0;
              dbz_reg     <= 1'b0;
              divisor_reg <= divisor;
              r_reg       <= '0;
              q_reg       <= dividend;
              cnt_reg     <= '0;
            end
          end
        end

        RUN: begin
          // Operand inputs and start are not looked at here, so the
          // operation in flight cannot be disturbed.
          r_reg   <= r_next;
          q_reg   <= q_next;
          cnt_reg <= cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_LAST) begin
            state_reg     <= DONE;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b1;
            quotient_reg  <= q_next;
            remainder_reg <= r_next[DIVISOR_W-1:0];
          end
        end

        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_reg;
  assign done        = done_reg;
  assign div_by_zero = dbz_reg;
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;

endmodule
